// File: rtl/io_wdt_pkg.sv
// Shared definitions for the io_wdt watchdog: register map, kick key, CTRL bits, FSM states.
package io_wdt_pkg;

  // Word offsets from BASE_ADR
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_KICK   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_COUNT  = 3'd4;
  localparam logic [2:0] NUM_REGS   = 3'd5;

  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

  // CTRL bit indices
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_RST_EN = 2;
  localparam int unsigned CTRL_LOCK   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StWarn  = 2'd2,
    StBite  = 2'd3
  } wdt_state_e;

  // Widen a register offset to the bus word-address width
  function automatic logic [13:0] off_adr(input logic [2:0] off);
    return {11'b0, off};
  endfunction

endpackage

// File: rtl/io_wdt_cntr.sv
// 32-bit watchdog down-counter: reload has priority, a tick at zero wraps to the reload value.
module io_wdt_cntr #(
  parameter logic [31:0] RESET_VAL = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        tick,
  input  logic [31:0] load_val,
  output logic [31:0] count,
  output logic        zero
);

  logic [31:0] count_q;

  assign count = count_q;
  assign zero  = (count_q == 32'd0);

  // Count state: explicit reload, otherwise decrement per tick with wrap-to-reload on zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick) begin
      count_q <= zero ? load_val : count_q - 32'd1;
    end
  end

endmodule

// File: rtl/io_wdt.sv
// Watchdog timer on the dma_io bus: register decode, read-chain link, warn/bite state machine.
module io_wdt
  import io_wdt_pkg::*;
#(
  parameter logic [13:0] BASE_ADR     = 14'h3C00,
  parameter logic [31:0] DEFAULT_LOAD = 32'h0100_0000,
  parameter int unsigned RST_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic        cpu_run_state,
  output logic        wdt_irq,
  output logic        wdt_irq_1shot,
  output logic        wdt_rst_req
);

  localparam int unsigned BiteW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  wdt_state_e  state_q;
  logic [BiteW-1:0] bite_cnt_q;
  logic        irq_1shot_q, rst_req_q;
  logic        en_q, irq_en_q, rst_en_q, lock_q;
  logic [31:0] load_q;
  logic        warn_q, bite_q;
  logic        hit_q;
  logic [31:0] rdata_q;

  logic [13:0] woff, roff;
  logic        wr_ctrl, wr_load, wr_kick, wr_status, rd_hit;
  logic [31:0] rd_val, count;
  logic        cnt_zero, active, tick, kick_ok, kick_bad, expiry;
  logic        enter_bite, bite_done, warn_set, cnt_load, warn_d;

  // Offsets wrap below BASE_ADR, so a single unsigned compare covers the decode window
  assign woff      = dma_io_wadr - BASE_ADR;
  assign roff      = dma_io_radr - BASE_ADR;
  assign wr_ctrl   = dma_io_we & (woff == off_adr(OFF_CTRL));
  assign wr_load   = dma_io_we & (woff == off_adr(OFF_LOAD));
  assign wr_kick   = dma_io_we & (woff == off_adr(OFF_KICK));
  assign wr_status = dma_io_we & (woff == off_adr(OFF_STATUS));
  assign rd_hit    = dma_io_radr_en & (roff < off_adr(NUM_REGS));

  assign active   = (state_q == StCount) | (state_q == StWarn);
  assign tick     = en_q & cpu_run_state & active;
  assign kick_ok  = wr_kick & (dma_io_wdata == KICK_KEY) & active;
  assign kick_bad = wr_kick & (dma_io_wdata != KICK_KEY) & lock_q & rst_en_q &
                    (state_q != StBite);
  // A valid kick on the expiry cycle suppresses the expiry
  assign expiry   = tick & cnt_zero & ~kick_ok;

  assign enter_bite = kick_bad | ((state_q == StWarn) & expiry & rst_en_q);
  assign bite_done  = (state_q == StBite) & (bite_cnt_q == '0);
  assign warn_set   = expiry & ~enter_bite;
  assign cnt_load   = (state_q == StIdle) | kick_ok;

  // A new warn beats a simultaneous W1C
  assign warn_d = (warn_q & ~(wr_status & dma_io_wdata[0])) | warn_set;

  io_wdt_cntr #(
    .RESET_VAL(DEFAULT_LOAD)
  ) u_cntr (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .tick     (tick),
    .load_val (load_q),
    .count    (count),
    .zero     (cnt_zero)
  );

  // Read mux of the pre-write register values
  always_comb begin
    rd_val = 32'd0;
    case (roff[2:0])
      OFF_CTRL:   rd_val = {28'd0, lock_q, rst_en_q, irq_en_q, en_q};
      OFF_LOAD:   rd_val = load_q;
      OFF_STATUS: rd_val = {30'd0, bite_q, warn_q};
      OFF_COUNT:  rd_val = count;
      default:    rd_val = 32'd0;
    endcase
  end

  // Watchdog FSM with registered irq pulse and reset-request pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bite_cnt_q  <= '0;
      irq_1shot_q <= 1'b0;
      rst_req_q   <= 1'b0;
    end else begin
      irq_1shot_q <= warn_set;
      if (enter_bite) begin
        state_q    <= StBite;
        rst_req_q  <= 1'b1;
        bite_cnt_q <= BiteW'(RST_CYCLES - 1);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (en_q) state_q <= StCount;
          end
          StCount, StWarn: begin
            if (!en_q) begin
              state_q <= StIdle;
            end else if (kick_ok) begin
              state_q <= StCount;
            end else if (expiry) begin
              state_q <= StWarn;
            end
          end
          StBite: begin
            if (bite_done) begin
              rst_req_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              bite_cnt_q <= bite_cnt_q - 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Software-visible registers and the read-chain capture
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      rst_en_q <= 1'b0;
      lock_q   <= 1'b0;
      load_q   <= DEFAULT_LOAD;
      warn_q   <= 1'b0;
      bite_q   <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      hit_q <= rd_hit;
      if (rd_hit) rdata_q <= rd_val;
      if (wr_ctrl && !lock_q) begin
        en_q     <= dma_io_wdata[CTRL_EN];
        irq_en_q <= dma_io_wdata[CTRL_IRQ_EN];
        rst_en_q <= dma_io_wdata[CTRL_RST_EN];
        lock_q   <= dma_io_wdata[CTRL_LOCK];
      end
      // End of the bite pulse disarms the dog regardless of a concurrent CTRL write
      if (bite_done) begin
        en_q   <= 1'b0;
        bite_q <= 1'b1;
      end
      if (wr_load && !lock_q) load_q <= dma_io_wdata;
      warn_q <= warn_d;
    end
  end

  assign dma_io_rdata  = hit_q ? rdata_q : dma_io_rdata_in;
  assign wdt_irq       = warn_q & irq_en_q;
  assign wdt_irq_1shot = irq_1shot_q;
  assign wdt_rst_req   = rst_req_q;

endmodule
